pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, branch-flush and debug halt/step controller for a
// 5-stage in-order pipeline.
//
// Ports:
//   CLK, RESET_N              clock, asynchronous active-low reset
//   rs1_ID, rs2_ID            source registers of the instruction in ID
//   wrin_EX, MemRead_EX       destination / load flag of the instruction in EX
//   PCSrc                     taken branch resolved in MEM
//   halt_req, step_req,
//   resume_req                debug requests, level-sampled
//   PCWrite, IFIDWrite        PC and IF/ID load enables
//   ID_bubble                 zero the ID control signals into ID/EX
//   IF_flush, ID_flush,
//   EX_flush                  synchronous clears of IF/ID, ID/EX, EX/MEM
//   halted                    pipeline empty and frozen
//   step_done                 registered one-cycle pulse on single-step finish
//   stall_cnt                 saturating count of load-use stall cycles
module pipe_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       wrin_EX,
    input  logic             MemRead_EX,
    input  logic             PCSrc,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             ID_bubble,
    output logic             IF_flush,
    output logic             ID_flush,
    output logic             EX_flush,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALT, STEP} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             step_flag_q, step_flag_d;
    logic             step_done_q, step_done_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             haz;
    logic             stall_inc;

    // x0 never creates a dependency, so a load to x0 cannot stall.
    assign haz = MemRead_EX && (wrin_EX != 5'd0) &&
                 ((wrin_EX == rs1_ID) || (wrin_EX == rs2_ID));

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        step_flag_d = step_flag_q;
        step_done_d = 1'b0;
        stall_inc   = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        ID_bubble   = 1'b0;
        IF_flush    = 1'b0;
        ID_flush    = 1'b0;
        EX_flush    = 1'b0;
        halted      = 1'b0;

        case (state_q)
            RUN: begin
                // A taken branch wins over both the hazard and a halt request;
                // halt is simply looked at again next cycle.
                if (PCSrc) begin
                    IF_flush = 1'b1;
                    ID_flush = 1'b1;
                    EX_flush = 1'b1;
                end else if (haz) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    ID_bubble = 1'b1;
                    stall_inc = 1'b1;
                end else if (halt_req) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end
            end
            DRAIN: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                ID_bubble = 1'b1;
                if (PCSrc) begin
                    // Load the branch target, kill the wrong path and restart
                    // the drain so the flushed stages are counted again.
                    PCWrite  = 1'b1;
                    IF_flush = 1'b1;
                    ID_flush = 1'b1;
                    EX_flush = 1'b1;
                    dcnt_d   = '0;
                end else if (dcnt_q == DLAST) begin
                    state_d     = HALT;
                    dcnt_d      = '0;
                    step_done_d = step_flag_q;
                    step_flag_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            HALT: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                ID_bubble = 1'b1;
                halted    = 1'b1;
                if (resume_req)    state_d = RUN;
                else if (step_req) state_d = STEP;
            end
            STEP: begin
                // The held instruction advances one stage, then the pipe is
                // drained behind it.
                if (PCSrc) begin
                    IF_flush    = 1'b1;
                    ID_flush    = 1'b1;
                    EX_flush    = 1'b1;
                    state_d     = DRAIN;
                    dcnt_d      = '0;
                    step_flag_d = 1'b1;
                end else if (haz) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    ID_bubble = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    state_d     = DRAIN;
                    dcnt_d      = '0;
                    step_flag_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_inc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= RUN;
            dcnt_q      <= '0;
            step_flag_q <= 1'b0;
            step_done_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            step_flag_q <= step_flag_d;
            step_done_q <= step_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign step_done = step_done_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (CNT_W=4 so saturation is
// reachable). Each entry carries inputs plus the expected outputs for that
// cycle; expectations are pushed when the inputs are driven and popped at
// the following falling edge.
module tb_pipe_ctrl;

    localparam int CW = 4;

    // Expected control vectors:
    // {PCWrite, IFIDWrite, ID_bubble, IF_flush, ID_flush, EX_flush, halted, step_done}
    localparam logic [7:0] DEF = 8'b1100_0000;
    localparam logic [7:0] STL = 8'b0010_0000;
    localparam logic [7:0] FLS = 8'b1101_1100;
    localparam logic [7:0] DRN = 8'b0010_0000;
    localparam logic [7:0] DFL = 8'b1011_1100;
    localparam logic [7:0] HLT = 8'b0010_0010;
    localparam logic [7:0] HSD = 8'b0010_0011;

    typedef struct packed {
        logic h, s, r, pc, mr;
        logic [4:0] w, a, b;
        logic [7:0] ctl;
        logic [CW-1:0] cnt;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [4:0]    rs1_ID, rs2_ID, wrin_EX;
    logic          MemRead_EX, PCSrc, halt_req, step_req, resume_req;
    logic          PCWrite, IFIDWrite, ID_bubble, IF_flush, ID_flush, EX_flush;
    logic          halted, step_done;
    logic [CW-1:0] stall_cnt;

    logic [CW+7:0] sb[$];
    logic [CW+7:0] e, got;
    int            n_vec = 0;
    int            n_err = 0;

    pipe_ctrl #(.CNT_W(CW), .DRAIN_CYC(3)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .wrin_EX(wrin_EX),
        .MemRead_EX(MemRead_EX), .PCSrc(PCSrc),
        .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .ID_bubble(ID_bubble),
        .IF_flush(IF_flush), .ID_flush(ID_flush), .EX_flush(EX_flush),
        .halted(halted), .step_done(step_done), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t v(input logic h, s, r, pc, mr,
                               input logic [4:0] w, a, b,
                               input logic [7:0] ctl, input logic [CW-1:0] cnt);
        vec_t x;
        x = '{h:h, s:s, r:r, pc:pc, mr:mr, w:w, a:a, b:b, ctl:ctl, cnt:cnt};
        return x;
    endfunction

    // Idle inputs / load-use hazard on x5 (lw x5 ; add x6,x5,x1).
    function automatic vec_t idle(input logic h, s, r, pc,
                                  input logic [7:0] ctl, input logic [CW-1:0] cnt);
        return v(h, s, r, pc, 1'b0, 5'd0, 5'd0, 5'd0, ctl, cnt);
    endfunction
    function automatic vec_t hz(input logic h, pc,
                                input logic [7:0] ctl, input logic [CW-1:0] cnt);
        return v(h, 1'b0, 1'b0, pc, 1'b1, 5'd5, 5'd5, 5'd1, ctl, cnt);
    endfunction

    function automatic logic [CW+7:0] obs();
        return {PCWrite, IFIDWrite, ID_bubble, IF_flush, ID_flush, EX_flush,
                halted, step_done, stall_cnt};
    endfunction

    task automatic apply(input vec_t x);
        halt_req   = x.h;
        step_req   = x.s;
        resume_req = x.r;
        PCSrc      = x.pc;
        MemRead_EX = x.mr;
        wrin_EX    = x.w;
        rs1_ID     = x.a;
        rs2_ID     = x.b;
        sb.push_back({x.ctl, x.cnt});
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        apply(idle(0, 0, 0, 0, DEF, 0));
        #3;
        e = sb.pop_front(); got = obs(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL reset_held: got %b want %b", got, e);
        end
        @(negedge CLK); RESET_N = 1'b1;
        @(posedge CLK); #1;
        apply(idle(0, 0, 0, 0, DEF, 0));
        @(negedge CLK);
        e = sb.pop_front(); got = obs(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL reset_release: got %b want %b", got, e);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_load_use();
        vec_t t[$];
        t = '{hz(0, 0, STL, 0), idle(0, 0, 0, 0, DEF, 1),
              v(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, DEF, 1),   // load to x0
              v(0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd0, DEF, 1),   // not a load
              v(0, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, STL, 1),   // rs2 match
              idle(0, 0, 0, 0, DEF, 2)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            e = sb.pop_front(); got = obs(); n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL load_use[%0d]: got %b want %b", i, got, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_branch_haz();
        vec_t t[$];
        t = '{hz(0, 1, FLS, 2), idle(0, 0, 0, 0, DEF, 2)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            e = sb.pop_front(); got = obs(); n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL branch_haz[%0d]: got %b want %b", i, got, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_halt();
        vec_t t[$];
        t = '{hz(1, 0, STL, 2),              // halt deferred by the stall
              idle(1, 0, 0, 0, DEF, 3),      // accepted, cycle behaves as RUN
              idle(0, 0, 0, 0, DRN, 3), idle(1, 0, 0, 0, DRN, 3),
              idle(0, 0, 0, 0, DRN, 3),
              idle(1, 0, 0, 0, HLT, 3), hz(0, 0, HLT, 3),
              idle(0, 0, 0, 0, HLT, 3)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            e = sb.pop_front(); got = obs(); n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL halt[%0d]: got %b want %b", i, got, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_step();
        vec_t t[$];
        t = '{idle(0, 1, 0, 0, HLT, 3), idle(0, 0, 0, 0, DEF, 3),
              idle(0, 0, 0, 0, DRN, 3), idle(0, 0, 0, 0, DRN, 3),
              idle(0, 0, 0, 0, DRN, 3), idle(0, 0, 0, 0, HSD, 3),
              idle(0, 0, 0, 0, HLT, 3),
              // step that hits a load-use hazard stalls inside STEP
              idle(0, 1, 0, 0, HLT, 3), hz(0, 0, STL, 3),
              idle(0, 0, 0, 0, DEF, 4), idle(0, 0, 0, 0, DRN, 4),
              idle(0, 0, 0, 0, DRN, 4), idle(0, 0, 0, 0, DRN, 4),
              idle(0, 0, 0, 0, HSD, 4), idle(0, 0, 0, 0, HLT, 4)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            e = sb.pop_front(); got = obs(); n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL step[%0d]: got %b want %b", i, got, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_resume();
        vec_t t[$];
        t = '{idle(0, 1, 1, 0, HLT, 4), idle(0, 0, 0, 0, DEF, 4),
              idle(0, 0, 0, 0, DEF, 4), idle(0, 0, 0, 0, DEF, 4)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            e = sb.pop_front(); got = obs(); n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL resume[%0d]: got %b want %b", i, got, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_drain_branch();
        vec_t t[$];
        t = '{idle(1, 0, 0, 0, DEF, 4), idle(0, 0, 0, 0, DRN, 4),
              idle(0, 0, 0, 1, DFL, 4), idle(0, 0, 0, 0, DRN, 4),
              idle(0, 0, 0, 0, DRN, 4), idle(0, 0, 0, 0, DRN, 4),
              idle(0, 0, 0, 0, HLT, 4), idle(0, 0, 1, 0, HLT, 4),
              idle(0, 0, 0, 0, DEF, 4)};
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            e = sb.pop_front(); got = obs(); n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL drain_branch[%0d]: got %b want %b", i, got, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_drain();
        vec_t t[$];
        t = '{idle(1, 0, 0, 0, DEF, 4), idle(0, 0, 0, 0, DRN, 4),
              idle(0, 0, 0, 0, DEF, 0), idle(0, 0, 0, 0, DEF, 0),
              idle(0, 0, 0, 0, DEF, 0)};
        foreach (t[i]) begin
            apply(t[i]);
            if (i == 2) begin
                #1 RESET_N = 1'b0;
            end
            if (i == 3) RESET_N = 1'b1;
            @(negedge CLK);
            e = sb.pop_front(); got = obs(); n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL reset_mid_drain[%0d]: got %b want %b", i, got, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_saturate();
        vec_t t[$];
        for (int k = 0; k < 18; k++)
            t.push_back(hz(0, 0, STL, CW'((k > 15) ? 15 : k)));
        t.push_back(idle(0, 0, 0, 0, DEF, 15));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            e = sb.pop_front(); got = obs(); n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL saturate[%0d]: got %b want %b", i, got, e);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_haz();
        test_halt();
        test_step();
        test_resume();
        test_drain_branch();
        test_reset_mid_drain();
        test_saturate();
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
